// File: rtl/fir_xifu_wb_queue.sv
// Writeback queue for the FIR XIFU coprocessor: holds issued instructions in program order,
// absorbs in-order memory data and out-of-order commit/kill, and retires the oldest entry.
module fir_xifu_wb_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned XLEN     = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          in_instr_i,
  input  logic [ID_WIDTH-1:0] in_id_i,
  input  logic [XLEN-1:0]     in_result_i,
  input  logic [4:0]          in_rd_i,
  input  logic [4:0]          in_rs1_i,
  input  logic                mem_valid_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic                rf_we_o,
  output logic [4:0]          rf_rd_o,
  output logic [XLEN-1:0]     rf_wdata_o,
  output logic                clear_valid_o,
  output logic [ID_WIDTH-1:0] clear_id_o,
  output logic                mem_err_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {InstrInvalid, InstrLw, InstrSw, InstrDotp} instr_e;

  instr_e                instr_q  [DEPTH];
  logic [ID_WIDTH-1:0]   id_q     [DEPTH];
  logic [XLEN-1:0]       result_q [DEPTH];
  logic [XLEN-1:0]       rdata_q  [DEPTH];
  logic [4:0]            rd_q     [DEPTH];
  logic [4:0]            rs1_q    [DEPTH];
  logic [DEPTH-1:0]      valid_q, committed_q, killed_q, mem_done_q;
  logic [PtrW-1:0]       head_q, tail_q;
  logic [CntW-1:0]       count_q;
  logic                  mem_err_q;

  logic                  full, enq, pop, head_ok, head_live, head_killed;
  logic                  mem_hit, mem_to_new, in_ldst, in_commit_hit, id_dup;
  logic [PtrW-1:0]       mem_idx;
  logic [DEPTH-1:0]      commit_hit;

  always_comb begin
    full          = (count_q == CntW'(DEPTH));
    enq           = in_valid_i && !full && (in_instr_i != InstrInvalid);
    in_ldst       = (in_instr_i == InstrLw) || (in_instr_i == InstrSw);
    head_killed   = killed_q[head_q];
    head_ok       = valid_q[head_q] && (head_killed || (committed_q[head_q] &&
                    (instr_q[head_q] == InstrDotp || mem_done_q[head_q])));
    head_live     = head_ok && !head_killed;
    pop           = head_ok && (head_killed || result_ready_i);

    // Oldest pending LW/SW, scanning from head in program order.
    mem_hit = 1'b0;
    mem_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!mem_hit && valid_q[head_q + PtrW'(k)] && !mem_done_q[head_q + PtrW'(k)] &&
          !killed_q[head_q + PtrW'(k)] && (instr_q[head_q + PtrW'(k)] == InstrLw ||
          instr_q[head_q + PtrW'(k)] == InstrSw)) begin
        mem_hit = 1'b1;
        mem_idx = head_q + PtrW'(k);
      end
    end
    mem_to_new    = mem_valid_i && !mem_hit && enq && in_ldst;
    in_commit_hit = commit_valid_i && (commit_id_i == in_id_i);

    id_dup = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      commit_hit[i] = commit_valid_i && valid_q[i] && (id_q[i] == commit_id_i);
      if (valid_q[i] && (id_q[i] == in_id_i) && !(pop && (PtrW'(i) == head_q))) id_dup = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i]  <= InstrInvalid;
        id_q[i]     <= '0;
        result_q[i] <= '0;
        rdata_q[i]  <= '0;
        rd_q[i]     <= '0;
        rs1_q[i]    <= '0;
      end
      valid_q     <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      mem_done_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (commit_hit[i]) begin
          if (!commit_kill_i)       committed_q[i] <= 1'b1;
          else if (!committed_q[i]) killed_q[i]    <= 1'b1;
        end
      end
      if (mem_valid_i && mem_hit) begin
        mem_done_q[mem_idx] <= 1'b1;
        rdata_q[mem_idx]    <= mem_rdata_i;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (enq) begin
        instr_q[tail_q]     <= instr_e'(in_instr_i);
        id_q[tail_q]        <= in_id_i;
        result_q[tail_q]    <= in_result_i;
        rd_q[tail_q]        <= in_rd_i;
        rs1_q[tail_q]       <= in_rs1_i;
        rdata_q[tail_q]     <= mem_to_new ? mem_rdata_i : '0;
        valid_q[tail_q]     <= 1'b1;
        committed_q[tail_q] <= in_commit_hit && !commit_kill_i;
        killed_q[tail_q]    <= in_commit_hit && commit_kill_i;
        mem_done_q[tail_q]  <= mem_to_new;
        tail_q              <= tail_q + 1'b1;
      end
      if (enq && !pop)      count_q <= count_q + 1'b1;
      else if (!enq && pop) count_q <= count_q - 1'b1;
      mem_err_q <= mem_valid_i && !mem_hit && !mem_to_new;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && enq) assert (!id_dup) else $error("duplicate id %0h enqueued", in_id_i);
  end

  always_comb begin
    in_ready_o     = !full;
    result_valid_o = head_live;
    result_id_o    = head_live ? id_q[head_q] : '0;
    result_data_o  = head_live ? result_q[head_q] : '0;
    result_rd_o    = head_live ? rs1_q[head_q] : '0;
    result_we_o    = head_live && (instr_q[head_q] != InstrDotp);
    rf_we_o        = pop && !head_killed && (instr_q[head_q] != InstrSw);
    rf_rd_o        = rf_we_o ? rd_q[head_q] : '0;
    rf_wdata_o     = !rf_we_o ? '0 : (instr_q[head_q] == InstrLw) ? rdata_q[head_q] : result_q[head_q];
    clear_valid_o  = pop;
    clear_id_o     = pop ? id_q[head_q] : '0;
    mem_err_o      = mem_err_q;
  end

endmodule

// File: tb/tb_fir_xifu_wb_queue.sv
// Bench for fir_xifu_wb_queue: directed scenarios plus random traffic, all checked against a
// queue-of-records model of the writeback stage.
module tb_fir_xifu_wb_queue;
  localparam int DEPTH = 4;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic in_valid_i, in_ready_o, mem_valid_i, commit_valid_i, commit_kill_i;
  logic result_valid_o, result_ready_i, result_we_o, rf_we_o, clear_valid_o, mem_err_o;
  logic [1:0] in_instr_i;
  logic [3:0] in_id_i, commit_id_i, result_id_o, clear_id_o;
  logic [31:0] in_result_i, mem_rdata_i, result_data_o, rf_wdata_o;
  logic [4:0] in_rd_i, in_rs1_i, result_rd_o, rf_rd_o;

  fir_xifu_wb_queue #(.DEPTH(DEPTH), .ID_WIDTH(4), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_id_i(in_id_i), .in_result_i(in_result_i), .in_rd_i(in_rd_i),
    .in_rs1_i(in_rs1_i), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_wdata_o(rf_wdata_o), .clear_valid_o(clear_valid_o),
    .clear_id_o(clear_id_o), .mem_err_o(mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] instr; logic [3:0] id; logic [31:0] result, rdata; logic [4:0] rd, rs1;
    bit committed, killed, mem_done;
  } ent_t;

  ent_t q[$];
  bit   err_m;
  int   errors = 0, checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit head_retirable();
    if (q.size() == 0) return 1'b0;
    return q[0].killed || (q[0].committed && (q[0].instr == 2'd3 || q[0].mem_done));
  endfunction

  function automatic bit id_used(logic [3:0] id);
    foreach (q[i]) if (q[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clr_in();
    in_valid_i = 0; in_instr_i = 0; in_id_i = 0; in_result_i = 0; in_rd_i = 0; in_rs1_i = 0;
    mem_valid_i = 0; mem_rdata_i = 0; commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
    result_ready_i = 0;
  endtask

  // Compare every output against what the model says the head should present this cycle.
  task automatic settle();
    bit rv, pop, rfwe;
    #1;
    rv = head_retirable() && !q[0].killed;
    pop = head_retirable() && (q[0].killed || result_ready_i);
    rfwe = pop && !q[0].killed && q[0].instr != 2'd2;
    chk("in_ready", 32'(in_ready_o), 32'(q.size() < DEPTH));
    chk("result_valid", 32'(result_valid_o), 32'(rv));
    if (rv) begin
      chk("result_id", 32'(result_id_o), 32'(q[0].id));
      chk("result_data", result_data_o, q[0].result);
      chk("result_rd", 32'(result_rd_o), 32'(q[0].rs1));
      chk("result_we", 32'(result_we_o), 32'(q[0].instr != 2'd3));
    end
    chk("rf_we", 32'(rf_we_o), 32'(rfwe));
    if (rfwe) begin
      chk("rf_rd", 32'(rf_rd_o), 32'(q[0].rd));
      chk("rf_wdata", rf_wdata_o, (q[0].instr == 2'd1) ? q[0].rdata : q[0].result);
    end
    chk("clear_valid", 32'(clear_valid_o), 32'(pop));
    if (pop) chk("clear_id", 32'(clear_id_o), 32'(q[0].id));
    chk("mem_err", 32'(mem_err_o), 32'(err_m));
  endtask

  // Advance the model with the current inputs, then let the DUT take the same edge.
  task automatic tick();
    bit enq, pop, errn;
    int mi;
    ent_t ne;
    pop = head_retirable() && (q[0].killed || result_ready_i);
    enq = in_valid_i && q.size() < DEPTH && in_instr_i != 2'd0;
    ne.instr = in_instr_i; ne.id = in_id_i; ne.result = in_result_i; ne.rd = in_rd_i;
    ne.rs1 = in_rs1_i; ne.rdata = 0; ne.committed = 0; ne.killed = 0; ne.mem_done = 0;
    errn = 0;
    if (mem_valid_i) begin
      mi = -1;
      foreach (q[i])
        if (mi < 0 && (q[i].instr == 2'd1 || q[i].instr == 2'd2) && !q[i].mem_done && !q[i].killed)
          mi = i;
      if (mi >= 0) begin q[mi].mem_done = 1; q[mi].rdata = mem_rdata_i; end
      else if (enq && (ne.instr == 2'd1 || ne.instr == 2'd2)) begin
        ne.mem_done = 1; ne.rdata = mem_rdata_i;
      end else errn = 1;
    end
    if (commit_valid_i) begin
      foreach (q[i]) if (q[i].id == commit_id_i) begin
        if (!commit_kill_i) q[i].committed = 1;
        else if (!q[i].committed) q[i].killed = 1;
      end
      if (enq && ne.id == commit_id_i) begin
        if (commit_kill_i) ne.killed = 1; else ne.committed = 1;
      end
    end
    if (pop) void'(q.pop_front());
    if (enq) q.push_back(ne);
    err_m = errn;
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic enq_in(logic [1:0] ins, logic [3:0] id, logic [31:0] res, logic [4:0] rd,
                        logic [4:0] rs1);
    in_valid_i = 1; in_instr_i = ins; in_id_i = id; in_result_i = res; in_rd_i = rd;
    in_rs1_i = rs1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_result_valid", 32'(result_valid_o), 32'd0);
    chk("rst_result_id", 32'(result_id_o), 32'd0);
    chk("rst_result_data", result_data_o, 32'd0);
    chk("rst_result_rd", 32'(result_rd_o), 32'd0);
    chk("rst_result_we", 32'(result_we_o), 32'd0);
    chk("rst_rf_we", 32'(rf_we_o), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd_o), 32'd0);
    chk("rst_rf_wdata", rf_wdata_o, 32'd0);
    chk("rst_clear_valid", 32'(clear_valid_o), 32'd0);
    chk("rst_clear_id", 32'(clear_id_o), 32'd0);
    chk("rst_mem_err", 32'(mem_err_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nid;
    int idx;
    clr_in();
    err_m = 0;
    #2;
    check_reset_outputs();
    @(posedge clk_i); #1;
    rst_ni = 1;

    // DOTP committed in its enqueue cycle retires the next cycle.
    clr_in(); enq_in(2'd3, 4'd2, 32'h1234, 5'd5, 5'd0);
    commit_valid_i = 1; commit_id_i = 2; result_ready_i = 1; cyc();
    clr_in(); result_ready_i = 1; settle();
    chk("dotp_valid", 32'(result_valid_o), 32'd1);
    chk("dotp_we", 32'(result_we_o), 32'd0);
    chk("dotp_rf_rd", 32'(rf_rd_o), 32'd5);
    chk("dotp_rf_wdata", rf_wdata_o, 32'h1234);
    chk("dotp_clear_id", 32'(clear_id_o), 32'd2);
    tick();

    // LW waits for its memory data, then retires.
    clr_in(); enq_in(2'd1, 4'd1, 32'h104, 5'd7, 5'd3);
    commit_valid_i = 1; commit_id_i = 1; result_ready_i = 1; cyc();
    clr_in(); result_ready_i = 1; cyc(); cyc();
    mem_valid_i = 1; mem_rdata_i = 32'hCAFE; cyc();
    clr_in(); result_ready_i = 1; settle();
    chk("lw_valid", 32'(result_valid_o), 32'd1);
    chk("lw_result_rd", 32'(result_rd_o), 32'd3);
    chk("lw_result_data", result_data_o, 32'h104);
    chk("lw_we", 32'(result_we_o), 32'd1);
    chk("lw_rf_wdata", rf_wdata_o, 32'hCAFE);
    tick();

    // Fill the queue, commit out of order; id0 gates everything behind it.
    for (int i = 0; i < 4; i++) begin
      clr_in(); enq_in(2'd3, 4'(i), 32'h100 + i, 5'(i + 8), 5'd0); cyc();
    end
    clr_in(); settle();
    chk("full_ready", 32'(in_ready_o), 32'd0);
    tick();
    for (int i = 1; i < 4; i++) begin
      clr_in(); result_ready_i = 1; commit_valid_i = 1; commit_id_i = 4'(i); cyc();
    end
    clr_in(); result_ready_i = 1; commit_valid_i = 1; commit_id_i = 0; cyc();
    clr_in(); result_ready_i = 1;
    for (int i = 0; i < 5; i++) cyc();

    // Killed LW is skipped by the memory pointer and cleared without a write.
    clr_in(); enq_in(2'd2, 4'd0, 32'h200, 5'd1, 5'd2); cyc();
    clr_in(); enq_in(2'd1, 4'd1, 32'h204, 5'd3, 5'd4); cyc();
    clr_in(); enq_in(2'd1, 4'd2, 32'h208, 5'd5, 5'd6); cyc();
    clr_in(); commit_valid_i = 1; commit_id_i = 1; commit_kill_i = 1; cyc();
    clr_in(); mem_valid_i = 1; mem_rdata_i = 32'hA0; cyc();
    clr_in(); mem_valid_i = 1; mem_rdata_i = 32'hA2; cyc();
    clr_in(); commit_valid_i = 1; commit_id_i = 0; result_ready_i = 1; cyc();
    clr_in(); commit_valid_i = 1; commit_id_i = 2; result_ready_i = 1; cyc();
    clr_in(); result_ready_i = 1;
    for (int i = 0; i < 4; i++) cyc();

    // Stray memory data on an empty queue, then a stalled result channel.
    clr_in(); mem_valid_i = 1; mem_rdata_i = 32'hDEAD; cyc();
    clr_in(); settle();
    chk("mem_err_pulse", 32'(mem_err_o), 32'd1);
    tick();
    clr_in(); enq_in(2'd3, 4'd7, 32'h5555, 5'd9, 5'd0); commit_valid_i = 1; commit_id_i = 7; cyc();
    clr_in();
    for (int i = 0; i < 5; i++) cyc();
    result_ready_i = 1; cyc(); cyc();

    // Reset with three entries pending.
    for (int i = 0; i < 3; i++) begin
      clr_in(); enq_in(2'd3, 4'(i + 4), 32'h300 + i, 5'(i), 5'd0); cyc();
    end
    clr_in(); rst_ni = 0; q.delete(); err_m = 0; #1;
    check_reset_outputs();
    @(posedge clk_i); #1;
    rst_ni = 1;
    clr_in(); enq_in(2'd3, 4'd4, 32'h777, 5'd2, 5'd0);
    commit_valid_i = 1; commit_id_i = 4; result_ready_i = 1; cyc();
    clr_in(); result_ready_i = 1; settle();
    chk("post_rst_rf_wdata", rf_wdata_o, 32'h777);
    tick();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      clr_in();
      if ($urandom_range(0, 99) < 60) begin
        nid = 4'($urandom_range(0, 15));
        for (int t = 0; t < 64 && id_used(nid); t++) nid = 4'($urandom_range(0, 15));
        if (!id_used(nid))
          enq_in(2'($urandom_range(0, 3)), nid, $urandom, 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
      end
      if (q.size() > 0 && $urandom_range(0, 99) < 40) begin
        idx = $urandom_range(0, q.size() - 1);
        commit_valid_i = 1; commit_id_i = q[idx].id;
        commit_kill_i = ($urandom_range(0, 9) < 2);
      end else if ($urandom_range(0, 99) < 5) begin
        commit_valid_i = 1; commit_id_i = 4'($urandom_range(0, 15));
        commit_kill_i = 1'($urandom_range(0, 1));
      end
      mem_valid_i = ($urandom_range(0, 99) < 30);
      mem_rdata_i = $urandom;
      result_ready_i = ($urandom_range(0, 99) < 70);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
